// File: rtl/branch_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl_pkg
// Brief    : Shared encodings for EX-stage branch resolution and redirect.
// Revision : 1.0
// ============================================================================
package branch_redirect_ctrl_pkg;

    localparam int         c_ctrl_jump_bit = 3;

    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_bne  = 3'b001;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_bltu = 3'b110;
    localparam logic [2:0] c_f3_bgeu = 3'b111;

    // Weakly not-taken
    localparam logic [1:0] c_bht_init = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_redirect_ctrl_judge.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl_judge
// Brief    : Branch comparator; taken for unconditional jumps or true condition.
// Revision : 1.0
// ============================================================================
module branch_redirect_ctrl_judge
    import branch_redirect_ctrl_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] rs1data,
    input  logic [31:0] rs2data,
    output logic        taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (rs1data == rs2data);
    assign w_lt  = ($signed(rs1data) < $signed(rs2data));
    assign w_ltu = (rs1data < rs2data);

    always_comb begin
        taken = 1'b0;
        if (ctrl[c_ctrl_jump_bit]) begin
            taken = 1'b1;
        end else begin
            case (ctrl[2:0])
                c_f3_beq:  taken = w_eq;
                c_f3_bne:  taken = !w_eq;
                c_f3_blt:  taken = w_lt;
                c_f3_bge:  taken = !w_lt;
                c_f3_bltu: taken = w_ltu;
                c_f3_bgeu: taken = !w_ltu;
                default:   taken = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : EX branch resolution, mispredict redirect/flush FSM and 2-bit BHT.
// Revision : 1.0
// ============================================================================
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_ctrl,
    input  logic [31:0] ex_rs1data,
    input  logic [31:0] ex_rs2data,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy,
    output logic [15:0] br_count,
    output logic [15:0] mis_count
);

    localparam int c_idx_w = $clog2(BHT_ENTRIES);
    localparam int c_cnt_w = $clog2(FLUSH_CYCLES) + 1;
    // REDIRECT covers the first flush cycle; FLUSH covers the remaining ones
    localparam logic [c_cnt_w-1:0] c_flush_load =
        c_cnt_w'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [1:0]           r_bht [BHT_ENTRIES];

    logic                 w_taken;
    logic                 w_accept;
    logic                 w_mispredict;
    logic [31:0]          w_corr_pc;
    logic [c_idx_w-1:0]   w_if_idx;
    logic [c_idx_w-1:0]   w_ex_idx;
    logic                 w_unused_pc_bits;

    branch_redirect_ctrl_judge u_judge (
        .ctrl    (ex_ctrl),
        .rs1data (ex_rs1data),
        .rs2data (ex_rs2data),
        .taken   (w_taken)
    );

    assign w_if_idx         = if_pc[c_idx_w+1:2];
    assign w_ex_idx         = ex_pc[c_idx_w+1:2];
    assign w_unused_pc_bits = ^{if_pc[31:c_idx_w+2], if_pc[1:0]};

    // No bypass: a same-cycle update is visible only from the next cycle
    assign if_pred_taken = r_bht[w_if_idx][1];

    assign w_accept     = ex_valid && !ex_stall && (r_state == ST_IDLE);
    assign w_mispredict = (w_taken != ex_pred_taken);
    assign w_corr_pc    = w_taken ? ex_target : (ex_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            busy           <= 1'b0;
            br_count       <= '0;
            mis_count      <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= c_bht_init;
            end
        end else begin
            if (w_accept) begin
                if (br_count != 16'hFFFF) begin
                    br_count <= br_count + 16'd1;
                end
                if (w_mispredict && (mis_count != 16'hFFFF)) begin
                    mis_count <= mis_count + 16'd1;
                end
                if (!ex_ctrl[c_ctrl_jump_bit]) begin
                    if (w_taken) begin
                        if (r_bht[w_ex_idx] != 2'b11) begin
                            r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
                        end
                    end else if (r_bht[w_ex_idx] != 2'b00) begin
                        r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_mispredict) begin
                        r_state        <= ST_REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= w_corr_pc;
                        flush          <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    redirect_valid <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= c_flush_load;
                    end else begin
                        r_state <= ST_IDLE;
                        flush   <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        flush   <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
